// File: rtl/vec_grid_arbiter.sv
// rtl/vec_grid_arbiter.sv - single-port vector RAM arbiter: read priority, buffered writes, grid clear
module vec_grid_arbiter #(
    parameter int VEC_CORD_WIDTH = 5,
    parameter int GRID_COLS      = 40,
    parameter int GRID_ROWS      = 32,
    parameter int IDX_WIDTH      = 6,
    parameter int ADDR_WIDTH     = 11,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr_req,
    output logic                          clear_busy,
    input  logic                          wr_req,
    input  logic [IDX_WIDTH-1:0]          wr_row,
    input  logic [IDX_WIDTH-1:0]          wr_col,
    input  logic [VEC_CORD_WIDTH-1:0]     wr_vx,
    input  logic [VEC_CORD_WIDTH-1:0]     wr_vy,
    output logic                          wr_full,
    output logic [7:0]                    drop_count,
    input  logic                          rd_req,
    input  logic [IDX_WIDTH-1:0]          rd_row,
    input  logic [IDX_WIDTH-1:0]          rd_col,
    output logic                          rd_valid,
    output logic [VEC_CORD_WIDTH-1:0]     rd_vx,
    output logic [VEC_CORD_WIDTH-1:0]     rd_vy,
    output logic                          ram_en,
    output logic                          ram_we,
    output logic [ADDR_WIDTH-1:0]         ram_addr,
    output logic [2*VEC_CORD_WIDTH-1:0]   ram_wdata,
    input  logic [2*VEC_CORD_WIDTH-1:0]   ram_rdata
);
    localparam int DW    = 2 * VEC_CORD_WIDTH;
    localparam int TOTAL = GRID_ROWS * GRID_COLS;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(TOTAL - 1);
    localparam logic [IDX_WIDTH:0]    ROWS_L    = (IDX_WIDTH + 1)'(GRID_ROWS);
    localparam logic [IDX_WIDTH:0]    COLS_L    = (IDX_WIDTH + 1)'(GRID_COLS);
    localparam logic [CNT_W-1:0]      DEPTH_L   = CNT_W'(FIFO_DEPTH);

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    typedef struct packed {
        logic [IDX_WIDTH-1:0] row;
        logic [IDX_WIDTH-1:0] col;
        logic [DW-1:0]        data;
    } entry_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
    entry_t                  fifo_q [FIFO_DEPTH];
    entry_t                  fifo_d [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [7:0]              drop_q, drop_d;
    logic                    rd_valid_q, rd_valid_d;
    logic                    rd_ram_q, rd_ram_d;
    logic [DW-1:0]           rd_hold_q, rd_hold_d;
    logic [DW-1:0]           rd_cur;
    entry_t                  head;
    logic                    push, pop;

    function automatic logic in_range(input logic [IDX_WIDTH-1:0] row,
                                      input logic [IDX_WIDTH-1:0] col);
        return ({1'b0, row} < ROWS_L) && ({1'b0, col} < COLS_L);
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] box_addr(input logic [IDX_WIDTH-1:0] row,
                                                       input logic [IDX_WIDTH-1:0] col);
        return ADDR_WIDTH'(row) * ADDR_WIDTH'(GRID_COLS) + ADDR_WIDTH'(col);
    endfunction

    assign head       = fifo_q[rd_ptr_q];
    assign wr_full    = (cnt_q == DEPTH_L);
    assign clear_busy = (state_q == ST_CLEAR);
    assign drop_count = drop_q;
    assign rd_valid   = rd_valid_q;
    assign rd_vx      = rd_cur[DW-1:VEC_CORD_WIDTH];
    assign rd_vy      = rd_cur[VEC_CORD_WIDTH-1:0];

    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        drop_d     = drop_q;
        rd_valid_d = rd_req;
        rd_ram_d   = 1'b0;
        pop        = 1'b0;
        ram_en     = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = '0;
        ram_wdata  = '0;

        if (state_q == ST_CLEAR) begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = clr_cnt_q;
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == LAST_ADDR) begin
                state_d = ST_RUN;
            end
        end else if (rd_req) begin
            if (in_range(rd_row, rd_col)) begin
                ram_en   = 1'b1;
                ram_addr = box_addr(rd_row, rd_col);
                rd_ram_d = 1'b1;
            end
        end else if (cnt_q != '0) begin
            // Out-of-range entries still consume their pop slot, just without touching RAM.
            pop = 1'b1;
            if (in_range(head.row, head.col)) begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = box_addr(head.row, head.col);
                ram_wdata = head.data;
            end
        end

        if (clr_req) begin
            state_d   = ST_CLEAR;
            clr_cnt_d = '0;
        end

        push = wr_req && !wr_full;
        if (wr_req && wr_full && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
        if (push) begin
            fifo_d[wr_ptr_q] = '{row: wr_row, col: wr_col, data: {wr_vx, wr_vy}};
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 1'b1;
        end

        // Read data passes straight from the RAM in its valid cycle, then is held.
        if (rd_valid_q) begin
            rd_cur = rd_ram_q ? ram_rdata : '0;
        end else begin
            rd_cur = rd_hold_q;
        end
        rd_hold_d = rd_cur;

        if (!rst_n) begin
            ram_en    = 1'b0;
            ram_we    = 1'b0;
            ram_addr  = '0;
            ram_wdata = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_CLEAR;
            clr_cnt_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            drop_q     <= '0;
            rd_valid_q <= 1'b0;
            rd_ram_q   <= 1'b0;
            rd_hold_q  <= '0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            fifo_q     <= fifo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            drop_q     <= drop_d;
            rd_valid_q <= rd_valid_d;
            rd_ram_q   <= rd_ram_d;
            rd_hold_q  <= rd_hold_d;
        end
    end
endmodule

// File: tb/tb_vec_grid_arbiter.sv
// tb/tb_vec_grid_arbiter.sv - randomized scoreboard bench for vec_grid_arbiter
module tb_vec_grid_arbiter;
    localparam int VW = 5, COLS = 40, ROWS = 32, IW = 6, AW = 11, DEPTH = 4;
    localparam int TOTAL = ROWS * COLS;

    logic clk = 1'b0, rst_n = 1'b0, clr_req = 1'b0;
    logic clear_busy, wr_full, rd_valid, ram_en, ram_we;
    logic wr_req = 1'b0, rd_req = 1'b0;
    logic [IW-1:0] wr_row = '0, wr_col = '0, rd_row = '0, rd_col = '0;
    logic [VW-1:0] wr_vx = '0, wr_vy = '0, rd_vx, rd_vy;
    logic [7:0] drop_count;
    logic [AW-1:0] ram_addr;
    logic [2*VW-1:0] ram_wdata, ram_rdata;

    vec_grid_arbiter dut (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .clear_busy(clear_busy),
        .wr_req(wr_req), .wr_row(wr_row), .wr_col(wr_col), .wr_vx(wr_vx), .wr_vy(wr_vy),
        .wr_full(wr_full), .drop_count(drop_count),
        .rd_req(rd_req), .rd_row(rd_row), .rd_col(rd_col),
        .rd_valid(rd_valid), .rd_vx(rd_vx), .rd_vy(rd_vy),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    logic [2*VW-1:0] mem [0:2047];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= mem[ram_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: grid contents, pending-write queue, clear progress.
    typedef struct { int row; int col; logic [2*VW-1:0] data; } went_t;
    typedef struct { int cyc; logic we; int addr; logic [2*VW-1:0] data; } acc_t;
    typedef struct { int cyc; logic [2*VW-1:0] data; } rexp_t;
    logic [2*VW-1:0] grid [ROWS][COLS];
    went_t mq [$];
    acc_t  aq [$];
    rexp_t rq [$];
    int mclr_left, drops;
    logic exp_full, exp_busy;
    int exp_drop;
    int vectors = 0, errors = 0;
    logic [2*VW-1:0] last_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic inr(input int r, input int c);
        return (r < ROWS) && (c < COLS);
    endfunction

    task automatic zero_grid();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                grid[r][c] = '0;
    endtask

    task automatic step(input logic rr, input int rrow, input int rcol,
                        input logic wr, input int wrow, input int wcol,
                        input logic [VW-1:0] vx, input logic [VW-1:0] vy, input logic clr);
        went_t e;
        logic was_full;
        exp_full = (mq.size() == DEPTH);
        exp_drop = drops;
        exp_busy = (mclr_left > 0);
        rd_req = rr; rd_row = IW'(rrow); rd_col = IW'(rcol);
        wr_req = wr; wr_row = IW'(wrow); wr_col = IW'(wcol); wr_vx = vx; wr_vy = vy;
        clr_req = clr;
        was_full = exp_full;
        if (mclr_left > 0) begin
            aq.push_back('{cyc, 1'b1, TOTAL - mclr_left, '0});
            mclr_left--;
            if (rr) rq.push_back('{cyc, '0});
        end else if (rr) begin
            if (inr(rrow, rcol)) begin
                aq.push_back('{cyc, 1'b0, rrow * COLS + rcol, '0});
                rq.push_back('{cyc, grid[rrow][rcol]});
            end else begin
                rq.push_back('{cyc, '0});
            end
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            if (inr(e.row, e.col)) begin
                grid[e.row][e.col] = e.data;
                aq.push_back('{cyc, 1'b1, e.row * COLS + e.col, e.data});
            end
        end
        if (clr) begin
            mclr_left = TOTAL;
            zero_grid();
        end
        if (wr) begin
            if (was_full) drops = (drops < 255) ? drops + 1 : 255;
            else          mq.push_back('{wrow, wcol, {vx, vy}});
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0, 0, 0, '0, '0, 0);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0; rd_req = 0; wr_req = 0; clr_req = 0;
        mq.delete(); aq.delete(); rq.delete();
        drops = 0; mclr_left = TOTAL; zero_grid();
        #1;
        chk("rst_ram_en", 32'(ram_en), 0);
        chk("rst_ram_we", 32'(ram_we), 0);
        chk("rst_ram_addr", 32'(ram_addr), 0);
        chk("rst_ram_wdata", 32'(ram_wdata), 0);
        chk("rst_clear_busy", 32'(clear_busy), 1);
        chk("rst_wr_full", 32'(wr_full), 0);
        chk("rst_drop_count", 32'(drop_count), 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_rd_data", 32'({rd_vx, rd_vy}), 0);
        repeat (n) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Monitor: pops expectations whenever the DUT presents RAM traffic or read data.
    always @(negedge clk) begin
        acc_t a;
        rexp_t r;
        if (!rst_n) begin
            last_rd = '0;
        end else begin
            chk("wr_full", 32'(wr_full), 32'(exp_full));
            chk("drop_count", 32'(drop_count), 32'(exp_drop));
            chk("clear_busy", 32'(clear_busy), 32'(exp_busy));
            if (ram_en) begin
                if (aq.size() == 0) begin
                    chk("unexpected_ram_access", 32'(ram_addr), 32'hFFFF_FFFF);
                end else begin
                    a = aq.pop_front();
                    chk("ram_cycle", cyc, a.cyc);
                    chk("ram_we", 32'(ram_we), 32'(a.we));
                    chk("ram_addr", 32'(ram_addr), a.addr);
                    if (a.we) chk("ram_wdata", 32'(ram_wdata), 32'(a.data));
                end
            end
            if (rd_valid) begin
                if (rq.size() == 0) begin
                    chk("unexpected_rd_valid", 32'(rd_valid), 0);
                end else begin
                    r = rq.pop_front();
                    chk("rd_latency", cyc, r.cyc + 1);
                    chk("rd_data", 32'({rd_vx, rd_vy}), 32'(r.data));
                    last_rd = r.data;
                end
            end else begin
                chk("rd_hold", 32'({rd_vx, rd_vy}), 32'(last_rd));
            end
        end
    end

    initial begin
        int d0, rr, rw;
        do_reset(3);
        // Clear sweep with reads and one write arriving mid-sweep.
        idle(100);
        step(1, 0, 0, 0, 0, 0, '0, '0, 0);
        step(1, 3, 7, 1, 1, 1, 5'd9, 5'd22, 0);
        idle(TOTAL - 102 + 3);
        // Basic write then read.
        step(0, 0, 0, 1, 2, 5, -5'sd3, 5'sd7, 0);
        idle(2);
        step(1, 2, 5, 0, 0, 0, '0, '0, 0);
        step(1, 1, 1, 0, 0, 0, '0, '0, 0);
        idle(2);
        // Read priority: reads starve the FIFO, extra writes drop.
        d0 = drops;
        for (int i = 0; i < 10; i++)
            step(1, $urandom_range(0, ROWS - 1), $urandom_range(0, COLS - 1),
                 i < 6, 5, i, 5'($urandom), 5'($urandom), 0);
        chk("prio_full", 32'(wr_full), 1);
        chk("prio_drops", 32'(drop_count), 32'(d0 + 2));
        idle(6);
        for (int i = 0; i < 6; i++) step(1, 5, i, 0, 0, 0, '0, '0, 0);
        // Out-of-range write and read.
        step(1, 0, COLS, 1, ROWS, 0, 5'd1, 5'd1, 0);
        idle(3);
        // Mid-run clear with two queued writes.
        step(1, 0, 0, 1, 7, 1, 5'd4, -5'sd4, 0);
        step(1, 0, 1, 1, 7, 2, -5'sd16, 5'd15, 0);
        step(1, 7, 1, 0, 0, 0, '0, '0, 1);
        chk("clr_restart_busy", 32'(clear_busy), 1);
        idle(TOTAL + 4);
        for (int i = 0; i < 4; i++) step(1, 7, i, 0, 0, 0, '0, '0, 0);
        step(1, 2, 5, 0, 0, 0, '0, '0, 0);
        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            rr = ($urandom_range(0, 15) == 0) ? ROWS + $urandom_range(0, 31) : $urandom_range(0, 3);
            rw = ($urandom_range(0, 15) == 0) ? ROWS + $urandom_range(0, 31) : $urandom_range(0, 3);
            step($urandom_range(0, 3) == 0, rr,
                 ($urandom_range(0, 15) == 0) ? COLS + $urandom_range(0, 23) : $urandom_range(0, 9),
                 $urandom_range(0, 1) == 0, rw,
                 ($urandom_range(0, 15) == 0) ? COLS + $urandom_range(0, 23) : $urandom_range(0, 9),
                 5'($urandom), 5'($urandom), $urandom_range(0, 299) == 0);
        end
        idle(TOTAL + 10);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 10; c++) step(1, r, c, 0, 0, 0, '0, '0, 0);
        // Drop saturation, then reset mid-drain.
        for (int i = 0; i < 304; i++) step(1, 0, 0, 1, 9, i % COLS, 5'($urandom), 5'($urandom), 0);
        chk("drop_saturated", 32'(drop_count), 255);
        idle(1);
        do_reset(2);
        idle(TOTAL + 4);
        for (int i = 0; i < 4; i++) step(1, 9, i, 0, 0, 0, '0, '0, 0);
        idle(3);
        chk("ram_queue_drained", aq.size(), 0);
        chk("rd_queue_drained", rq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
